// File: rtl/lfm_tx_pkg.sv
// ---------------------------------------------------------------------------
// lfm_tx_pkg
// Shared types and constants for the LFM pulse transmitter: the sequencer
// state encoding, sine-table geometry and the elaboration-time helper that
// produces one rounded sine table entry.
// ---------------------------------------------------------------------------
package lfm_tx_pkg;

  // Sequencer states: waiting for a request, emitting samples, and the quiet
  // listening window that fills the rest of each PRI.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    LISTEN = 2'd2
  } state_t;

  // Sine table geometry: the top LUT_AW phase bits address the table.
  localparam int LUT_AW    = 10;
  localparam int LUT_DEPTH = 1024;

  // Peak sine amplitude; full scale of a 12-bit signed sample.
  localparam int SIN_AMP = 2047;

  localparam real TWO_PI = 6.283185307179586;

  // Entry k of the sine table, round-half-away-from-zero of
  // SIN_AMP*sin(2*pi*k/LUT_DEPTH). Only ever evaluated with constant
  // arguments, so it folds away during elaboration.
  function automatic int sin_lut_entry(int k);
    real x;
    x = real'(SIN_AMP) * $sin(TWO_PI * real'(k) / real'(LUT_DEPTH));
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/lfm_sin_lut.sv
// ---------------------------------------------------------------------------
// lfm_sin_lut
// Synchronous 1024 x WIDTH sine ROM with a registered output. The table is
// generated at elaboration from lfm_tx_pkg::sin_lut_entry. When i_en is low
// the output register loads zero, so the sample stream is already blanked
// outside the transmit gate.
// ---------------------------------------------------------------------------
module lfm_sin_lut
  import lfm_tx_pkg::*;
#(
  parameter int WIDTH = 12
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic [LUT_AW-1:0]       i_addr,
  output logic signed [WIDTH-1:0] o_data
);

  logic signed [WIDTH-1:0] w_rom [LUT_DEPTH];
  logic signed [WIDTH-1:0] r_data;

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    assign w_rom[k] = WIDTH'(sin_lut_entry(k));
  end

  // Registered ROM read, zero when the gate is closed.
  // NOTE: only the output register is reset; the table is a constant ROM and
  // giving it a reset would stop it mapping onto block memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= w_rom[i_addr];
    end else begin
      r_data <= '0;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/lfm_pulse_tx.sv
// ---------------------------------------------------------------------------
// lfm_pulse_tx
// Transmit-side LFM pulse generator. A start request produces a coherent
// burst of NUM_PULSES identical linear-FM pulses, each PULSE_LEN samples long
// and repeated every PRI_LEN cycles. Samples come from a DDS: a phase
// accumulator driven by a frequency accumulator that ramps by K_WORD per
// sample, addressing a sine ROM.
//
// Output pipeline is two cycles (registered LUT address, registered LUT
// data); tx_gate and prf_sync travel through matching delay stages.
//
// Build option: define LFM_PULSE_TX_CONTINUOUS_EN to let a burst roll
// straight into the next one when start is high at the end of the last PRI.
//
// pulse_idx is $clog2(NUM_PULSES) bits wide, widened to one bit when
// NUM_PULSES is 1 so the port never collapses to zero width.
// ---------------------------------------------------------------------------
module lfm_pulse_tx
  import lfm_tx_pkg::*;
#(
  parameter int                 WIDTH      = 12,
  parameter int                 PHASE_W    = 32,
  parameter int                 PRI_LEN    = 4096,
  parameter int                 PULSE_LEN  = 800,
  parameter int                 NUM_PULSES = 16,
  parameter logic [PHASE_W-1:0] F0_WORD    = 32'h0CCC_CCCD,
  parameter logic [PHASE_W-1:0] K_WORD     = 32'h0000_4000,
  localparam int                IDX_W      = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    prf_sync,
  output logic                    tx_gate,
  output logic [IDX_W-1:0]        pulse_idx,
  output logic signed [WIDTH-1:0] if_out
);

  localparam int               CNT_W      = (PRI_LEN > 1) ? $clog2(PRI_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] PRI_LAST   = CNT_W'(PRI_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_PULSES - 1);

  // Sequencer state.
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_pulse_idx;
  logic               r_busy;

  // DDS accumulators; both wrap modulo 2^PHASE_W.
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_freq;

  // Output pipeline: stage 1 holds the LUT address, stage 2 the LUT data.
  logic [LUT_AW-1:0]       r_addr;
  logic                    r_gate1;
  logic                    r_sync1;
  logic                    r_gate2;
  logic                    r_sync2;
  logic signed [WIDTH-1:0] w_lut_data;

  // Burst sequencer: counts samples through each PRI, steps the accumulators
  // while a pulse is on air and reloads them at the start of every pulse so
  // all pulses in the burst are identical.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values; blocking here would let the
  // accumulators see each other's new values within the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pulse_idx <= '0;
      r_busy      <= 1'b0;
      r_phase     <= '0;
      r_freq      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= PULSE;
            r_cnt       <= '0;
            r_pulse_idx <= '0;
            r_busy      <= 1'b1;
            r_phase     <= '0;
            r_freq      <= F0_WORD;
          end
        end

        PULSE: begin
          r_phase <= r_phase + r_freq;
          r_freq  <= r_freq + K_WORD;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == PULSE_LAST) begin
            r_state <= LISTEN;
          end
        end

        LISTEN: begin
          if (r_cnt == PRI_LAST) begin
            if (r_pulse_idx == IDX_LAST) begin
`ifdef LFM_PULSE_TX_CONTINUOUS_EN
              if (start) begin
                // Roll into the next burst with no idle gap.
                r_state     <= PULSE;
                r_cnt       <= '0;
                r_pulse_idx <= '0;
                r_phase     <= '0;
                r_freq      <= F0_WORD;
              end else begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_pulse_idx <= '0;
                r_busy      <= 1'b0;
              end
`else
              r_state     <= IDLE;
              r_cnt       <= '0;
              r_pulse_idx <= '0;
              r_busy      <= 1'b0;
`endif
            end else begin
              r_state     <= PULSE;
              r_cnt       <= '0;
              r_pulse_idx <= r_pulse_idx + 1'b1;
              r_phase     <= '0;
              r_freq      <= F0_WORD;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output pipeline: register the LUT address and carry the gate and the
  // first-sample marker alongside it so they line up with the LUT data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_gate1 <= 1'b0;
      r_sync1 <= 1'b0;
      r_gate2 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_addr  <= r_phase[PHASE_W-1 -: LUT_AW];
      r_gate1 <= (r_state == PULSE);
      r_sync1 <= (r_state == PULSE) && (r_cnt == '0);
      r_gate2 <= r_gate1;
      r_sync2 <= r_sync1;
    end
  end

  lfm_sin_lut #(
    .WIDTH (WIDTH)
  ) u_sin_lut (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_gate1),
    .i_addr (r_addr),
    .o_data (w_lut_data)
  );

  assign busy      = r_busy;
  assign pulse_idx = r_pulse_idx;
  assign tx_gate   = r_gate2;
  assign prf_sync  = r_sync2;
  assign if_out    = w_lut_data;

endmodule

// File: tb/tb_lfm_pulse_tx.sv
// ---------------------------------------------------------------------------
// tb_lfm_pulse_tx
// Three generator instances with different parameter sets (fs/4 tone,
// short three-pulse burst, 800-sample chirp) are driven with randomized
// start timing, spurious starts while busy and a randomly placed reset
// abort. Expected samples come from the closed-form chirp phase
// n*F0 + K*n(n-1)/2 and a real-valued sine; expected timing from the
// burst schedule (pulse k at start + k*PRI, two-cycle output latency).
// Build option LFM_PULSE_TX_CONTINUOUS_EN switches the chained-burst
// expectation from a one-cycle idle gap to back-to-back bursts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lfm_pulse_tx;

  localparam int     NU          = 3;
  localparam int     PRI_T [NU]  = '{16, 16, 1024};
  localparam int     PL_T  [NU]  = '{8, 4, 800};
  localparam int     NP_T  [NU]  = '{1, 3, 2};
  localparam longint F0_T  [NU]  = '{64'h4000_0000, 64'h0CCC_CCCD, 64'h0};
  localparam longint K_T   [NU]  = '{64'h0, 64'h0100_0000, 64'h0040_0000};
  localparam real    PI          = 3.141592653589793;

`ifdef LFM_PULSE_TX_CONTINUOUS_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  // Elaboration-time legality of every parameter set used here.
  for (genvar g = 0; g < NU; g++) begin : g_param_chk
    if ((PL_T[g] + 2 > PRI_T[g]) || (NP_T[g] < 1)) begin : g_bad
      $error("illegal parameter set %0d: need PULSE_LEN+2 <= PRI_LEN and NUM_PULSES >= 1", g);
    end
  end

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                start_i [NU];
  logic                busy_o  [NU];
  logic                sync_o  [NU];
  logic                gate_o  [NU];
  logic signed [11:0]  if_o    [NU];
  logic [0:0]          idx_a;
  logic [1:0]          idx_b;
  logic [0:0]          idx_c;

  int n_vec = 0;
  int n_err = 0;

  lfm_pulse_tx #(
    .WIDTH(12), .PHASE_W(32), .PRI_LEN(PRI_T[0]), .PULSE_LEN(PL_T[0]),
    .NUM_PULSES(NP_T[0]), .F0_WORD(32'(F0_T[0])), .K_WORD(32'(K_T[0]))
  ) u_tone (
    .clk(clk), .rst(rst), .start(start_i[0]), .busy(busy_o[0]),
    .prf_sync(sync_o[0]), .tx_gate(gate_o[0]), .pulse_idx(idx_a), .if_out(if_o[0])
  );

  lfm_pulse_tx #(
    .WIDTH(12), .PHASE_W(32), .PRI_LEN(PRI_T[1]), .PULSE_LEN(PL_T[1]),
    .NUM_PULSES(NP_T[1]), .F0_WORD(32'(F0_T[1])), .K_WORD(32'(K_T[1]))
  ) u_burst (
    .clk(clk), .rst(rst), .start(start_i[1]), .busy(busy_o[1]),
    .prf_sync(sync_o[1]), .tx_gate(gate_o[1]), .pulse_idx(idx_b), .if_out(if_o[1])
  );

  lfm_pulse_tx #(
    .WIDTH(12), .PHASE_W(32), .PRI_LEN(PRI_T[2]), .PULSE_LEN(PL_T[2]),
    .NUM_PULSES(NP_T[2]), .F0_WORD(32'(F0_T[2])), .K_WORD(32'(K_T[2]))
  ) u_chirp (
    .clk(clk), .rst(rst), .start(start_i[2]), .busy(busy_o[2]),
    .prf_sync(sync_o[2]), .tx_gate(gate_o[2]), .pulse_idx(idx_c), .if_out(if_o[2])
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint idx_of(input int u);
    case (u)
      0:       return longint'(idx_a);
      1:       return longint'(idx_b);
      default: return longint'(idx_c);
    endcase
  endfunction

  // Ideal sine table value for a 10-bit phase address.
  function automatic int sine_ref(input int a);
    real x;
    x = 2047.0 * $sin(2.0 * PI * real'(a) / 1024.0);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // Sample n of a pulse from the closed-form chirp phase.
  function automatic int exp_sample(input int u, input int n);
    longint nn;
    longint ph;
    nn = n;
    ph = nn * F0_T[u] + K_T[u] * ((nn * (nn - 1)) / 2);
    ph = ph & 64'hFFFF_FFFF;
    return sine_ref(int'(ph >>> 22));
  endfunction

  task automatic check_quiet(input int u, input string tag);
    check($sformatf("%s u%0d busy", tag, u), busy_o[u], 0);
    check($sformatf("%s u%0d prf_sync", tag, u), sync_o[u], 0);
    check($sformatf("%s u%0d tx_gate", tag, u), gate_o[u], 0);
    check($sformatf("%s u%0d if_out", tag, u), if_o[u], 0);
  endtask

  task automatic idle_gap();
    int n;
    n = int'($urandom_range(0, 4));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) check_quiet(u, "idle");
    end
  endtask

  // Run nb chained bursts on unit u. start is held until the last burst is
  // accepted; with spur set, random start pulses are thrown in while busy.
  task automatic run_bursts(input int u, input int nb, input bit spur);
    int total, d, last_base, b, r, tt, s, k, exp_if;
    bit exp_busy, exp_gate, exp_sync;
    total     = NP_T[u] * PRI_T[u];
    d         = total + GAP;
    last_base = (nb - 1) * d;
    @(negedge clk);
    start_i[u] = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= last_base + total + 3; t++) begin
      @(negedge clk);
      b        = (t >= last_base) ? nb - 1 : t / d;
      r        = t - b * d;
      exp_busy = (r < total);
      tt       = r - 2;
      exp_gate = 1'b0;
      exp_sync = 1'b0;
      exp_if   = 0;
      k        = 0;
      if (tt >= 0 && tt < total) begin
        s        = tt % PRI_T[u];
        k        = tt / PRI_T[u];
        exp_gate = (s < PL_T[u]);
        exp_sync = (s == 0);
        if (exp_gate) exp_if = exp_sample(u, s);
      end
      check($sformatf("u%0d t%0d busy", u, t), busy_o[u], exp_busy);
      check($sformatf("u%0d t%0d tx_gate", u, t), gate_o[u], exp_gate);
      check($sformatf("u%0d t%0d prf_sync", u, t), sync_o[u], exp_sync);
      check($sformatf("u%0d t%0d if_out", u, t), if_o[u], exp_if);
      if (exp_gate) check($sformatf("u%0d t%0d pulse_idx", u, t), idx_of(u), k);
      if (t + 1 <= last_base)
        start_i[u] = 1'b1;
      else if (spur && (t + 1 < last_base + total))
        start_i[u] = 1'($urandom_range(0, 1));
      else
        start_i[u] = 1'b0;
    end
    start_i[u] = 1'b0;
  endtask

  // Reset unit 1 while pulse 1 is on air; everything must clear at once.
  task automatic abort_burst();
    int when;
    @(negedge clk);
    start_i[1] = 1'b1;
    @(posedge clk);
    when = PRI_T[1] + 2 + int'($urandom_range(0, PL_T[1] - 1));
    for (int t = 0; t <= when; t++) begin
      @(negedge clk);
      start_i[1] = 1'b0;
    end
    check("abort pulse1 gate", gate_o[1], 1);
    check("abort pulse1 idx", idx_of(1), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_quiet(1, "abort");
    check("abort pulse_idx", idx_of(1), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet(1, "post-abort");
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int u = 0; u < NU; u++) start_i[u] = 1'b0;
    repeat (2) @(negedge clk);
    // start pulsed while reset is held must have no effect
    for (int u = 0; u < NU; u++) start_i[u] = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check_quiet(u, "reset");
      check($sformatf("reset u%0d pulse_idx", u), idx_of(u), 0);
      start_i[u] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) check_quiet(u, "released");
    end

    for (int i = 0; i < 4; i++) begin
      idle_gap();
      run_bursts(0, 1, 1'($urandom_range(0, 1)));
      idle_gap();
      run_bursts(1, int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
    end
    idle_gap();
    run_bursts(2, 1, 1'b1);
    idle_gap();
    abort_burst();
    run_bursts(1, 1, 1'b0);
    idle_gap();
    run_bursts(1, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
